// File: rtl/alu_rr_arbiter_pkg.sv
// Shared types and constants for the round-robin Hack ALU arbiter.
// Holds the FSM state type, control-bit positions and named ALU operations.
package alu_rr_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  // Bit positions inside the 6-bit {zx,nx,zy,ny,f,no} control word
  localparam int unsigned ZX = 5;
  localparam int unsigned NX = 4;
  localparam int unsigned ZY = 3;
  localparam int unsigned NY = 2;
  localparam int unsigned F  = 1;
  localparam int unsigned NO = 0;

  localparam int unsigned CTRL_W = 6;

  localparam logic [5:0] ALU_ZERO = 6'b101010;
  localparam logic [5:0] ALU_NEG1 = 6'b111010;
  localparam logic [5:0] ALU_X    = 6'b001100;
  localparam logic [5:0] ALU_NOTX = 6'b001101;
  localparam logic [5:0] ALU_ADD  = 6'b000010;
  localparam logic [5:0] ALU_AND  = 6'b000000;

endpackage

// File: rtl/alu_rr_arbiter_if.sv
// Request/response bus between the requesters and the shared-ALU arbiter.
// Vector signals are packed per port: port i at [i*WIDTH +: WIDTH] / [i*6 +: 6].
interface alu_rr_arbiter_if #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned NREQ  = 2
);

  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ*WIDTH-1:0] req_x;
  logic [NREQ*WIDTH-1:0] req_y;
  logic [NREQ*6-1:0]     req_ctrl;
  logic [NREQ-1:0]       rsp_valid;
  logic [NREQ-1:0]       rsp_ready;
  logic [WIDTH-1:0]      rsp_out;
  logic                  rsp_zr;
  logic                  rsp_ng;
  logic                  busy;

  modport master (
    output req_valid, req_x, req_y, req_ctrl, rsp_ready,
    input  req_ready, rsp_valid, rsp_out, rsp_zr, rsp_ng, busy
  );

  modport slave (
    input  req_valid, req_x, req_y, req_ctrl, rsp_ready,
    output req_ready, rsp_valid, rsp_out, rsp_zr, rsp_ng, busy
  );

endinterface

// File: rtl/alu_rr_arbiter_hack_alu.sv
// Combinational Hack-style ALU: zx/nx on x, zy/ny on y, add or and, then no.
// zr and ng reflect the final (post-no) result.
module hack_alu
  import alu_rr_arbiter_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic [WIDTH-1:0]  i_x,
  input  logic [WIDTH-1:0]  i_y,
  input  logic [CTRL_W-1:0] i_ctrl,
  output logic [WIDTH-1:0]  o_out,
  output logic              o_zr,
  output logic              o_ng
);

  logic [WIDTH-1:0] w_x;
  logic [WIDTH-1:0] w_y;
  logic [WIDTH-1:0] w_f;

  always_comb begin
    w_x = i_ctrl[ZX] ? '0 : i_x;
    if (i_ctrl[NX]) w_x = ~w_x;
    w_y = i_ctrl[ZY] ? '0 : i_y;
    if (i_ctrl[NY]) w_y = ~w_y;
    w_f   = i_ctrl[F] ? (w_x + w_y) : (w_x & w_y);
    o_out = i_ctrl[NO] ? ~w_f : w_f;
    o_zr  = (o_out == '0);
    o_ng  = o_out[WIDTH-1];
  end

endmodule

// File: rtl/alu_rr_arbiter.sv
// Two-port round-robin arbiter sharing one Hack ALU: grant in IDLE, evaluate in
// EXEC, hold the registered result in RESP until the owning port accepts it.
module alu_rr_arbiter
  import alu_rr_arbiter_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned NREQ  = 2
) (
  input  logic            clk,
  input  logic            reset,
  alu_rr_arbiter_if.slave bus
);

  state_t              r_state;
  logic                r_ptr;
  logic                r_owner;
  logic [WIDTH-1:0]    r_x;
  logic [WIDTH-1:0]    r_y;
  logic [CTRL_W-1:0]   r_ctrl;
  logic [WIDTH-1:0]    r_out;
  logic                r_zr;
  logic                r_ng;
  logic [NREQ-1:0]     r_rsp_valid;

  logic                w_any;
  logic                w_win;
  logic [NREQ-1:0]     w_grant;
  logic [NREQ-1:0]     w_owner_oh;
  logic [WIDTH-1:0]    w_sel_x;
  logic [WIDTH-1:0]    w_sel_y;
  logic [CTRL_W-1:0]   w_sel_ctrl;
  logic [WIDTH-1:0]    w_alu_out;
  logic                w_alu_zr;
  logic                w_alu_ng;

  // Pointed port wins if valid, otherwise the other port (two-port revision)
  always_comb begin
    w_any      = |bus.req_valid;
    w_win      = bus.req_valid[r_ptr] ? r_ptr : ~r_ptr;
    w_grant    = '0;
    if (r_state == IDLE && w_any) w_grant[w_win] = 1'b1;
    w_owner_oh = '0;
    w_owner_oh[r_owner] = 1'b1;
    w_sel_x    = w_win ? bus.req_x[WIDTH +: WIDTH]       : bus.req_x[0 +: WIDTH];
    w_sel_y    = w_win ? bus.req_y[WIDTH +: WIDTH]       : bus.req_y[0 +: WIDTH];
    w_sel_ctrl = w_win ? bus.req_ctrl[CTRL_W +: CTRL_W]  : bus.req_ctrl[0 +: CTRL_W];
  end

  hack_alu #(
    .WIDTH (WIDTH)
  ) u_alu (
    .i_x    (r_x),
    .i_y    (r_y),
    .i_ctrl (r_ctrl),
    .o_out  (w_alu_out),
    .o_zr   (w_alu_zr),
    .o_ng   (w_alu_ng)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= IDLE;
      r_ptr       <= 1'b0;
      r_owner     <= 1'b0;
      r_x         <= '0;
      r_y         <= '0;
      r_ctrl      <= '0;
      r_out       <= '0;
      r_zr        <= 1'b0;
      r_ng        <= 1'b0;
      r_rsp_valid <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_any) begin
            r_x     <= w_sel_x;
            r_y     <= w_sel_y;
            r_ctrl  <= w_sel_ctrl;
            r_owner <= w_win;
            r_ptr   <= ~w_win;
            r_state <= EXEC;
          end
        end
        EXEC: begin
          r_out       <= w_alu_out;
          r_zr        <= w_alu_zr;
          r_ng        <= w_alu_ng;
          r_rsp_valid <= w_owner_oh;
          r_state     <= RESP;
        end
        RESP: begin
          if (bus.rsp_ready[r_owner]) begin
            r_rsp_valid <= '0;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.req_ready = w_grant;
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_out   = r_out;
  assign bus.rsp_zr    = r_zr;
  assign bus.rsp_ng    = r_ng;
  assign bus.busy      = (r_state != IDLE);

endmodule

// File: tb/tb_alu_rr_arbiter.sv
// Directed bench for alu_rr_arbiter: vector table of single-port operations plus
// hand-written arbitration, backpressure, fairness and reset sequences.
module tb_alu_rr_arbiter;
  import alu_rr_arbiter_pkg::*;

  localparam int unsigned W = 16;
  localparam int unsigned N = 2;

  logic clk;
  logic reset;

  alu_rr_arbiter_if #(.WIDTH(W), .NREQ(N)) bus ();

  alu_rr_arbiter #(.WIDTH(W), .NREQ(N)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int unsigned port;
    logic [15:0] x;
    logic [15:0] y;
    logic [5:0]  ctrl;
    logic [15:0] eo;
    logic        ezr;
    logic        eng;
  } vec_t;

  vec_t vecs[7];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [1:0] oh(input int unsigned p);
    logic [1:0] r;
    r = '0;
    r[p] = 1'b1;
    return r;
  endfunction

  task automatic drive(input int unsigned p, input logic [15:0] x, input logic [15:0] y,
                       input logic [5:0] c);
    bus.req_x[p*16 +: 16]  = x;
    bus.req_y[p*16 +: 16]  = y;
    bus.req_ctrl[p*6 +: 6] = c;
    bus.req_valid[p]       = 1'b1;
  endtask

  task automatic chk_rsp(input string tag, input int unsigned p, input logic [15:0] eo,
                         input logic ezr, input logic eng);
    chk({tag, " rsp_valid"}, bus.rsp_valid, oh(p));
    chk({tag, " rsp_out"},   bus.rsp_out, eo);
    chk({tag, " rsp_zr"},    bus.rsp_zr, ezr);
    chk({tag, " rsp_ng"},    bus.rsp_ng, eng);
    chk({tag, " req_ready in RESP"}, bus.req_ready, 2'b00);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{0, 16'h0005, 16'h0003, ALU_ADD,  16'h0008, 1'b0, 1'b0};
    vecs[1] = '{0, 16'h0003, 16'h0005, 6'b010011, 16'hFFFE, 1'b0, 1'b1};
    vecs[2] = '{0, 16'h8000, 16'h8000, ALU_ADD,  16'h0000, 1'b1, 1'b0};
    vecs[3] = '{1, 16'h1234, 16'h00FF, ALU_AND,  16'h0034, 1'b0, 1'b0};
    vecs[4] = '{1, 16'h1234, 16'h00FF, ALU_NOTX, 16'hEDCB, 1'b0, 1'b1};
    vecs[5] = '{1, 16'h1234, 16'h00FF, ALU_ZERO, 16'h0000, 1'b1, 1'b0};
    vecs[6] = '{1, 16'h1234, 16'h00FF, ALU_NEG1, 16'hFFFF, 1'b0, 1'b1};

    reset         = 1'b1;
    bus.req_valid = '0;
    bus.req_x     = '0;
    bus.req_y     = '0;
    bus.req_ctrl  = '0;
    bus.rsp_ready = '0;

    // Reset held three cycles with no requests
    repeat (3) begin
      @(negedge clk);
      chk("reset req_ready", bus.req_ready, 2'b00);
      chk("reset rsp_valid", bus.rsp_valid, 2'b00);
      chk("reset rsp_out",   bus.rsp_out, 16'h0000);
      chk("reset zr/ng",     {bus.rsp_zr, bus.rsp_ng}, 2'b00);
      chk("reset busy",      bus.busy, 1'b0);
    end
    reset = 1'b0;

    // Single-port vectors, rsp_ready tied high
    for (int i = 0; i < 7; i++) begin
      bus.rsp_ready = 2'b11;
      drive(vecs[i].port, vecs[i].x, vecs[i].y, vecs[i].ctrl);
      #1 chk("vec req_ready", bus.req_ready, oh(vecs[i].port));
      @(posedge clk); #1 bus.req_valid = '0;
      @(negedge clk);
      chk("vec EXEC busy", bus.busy, 1'b1);
      chk("vec EXEC rsp_valid", bus.rsp_valid, 2'b00);
      @(negedge clk);
      chk_rsp("vec", vecs[i].port, vecs[i].eo, vecs[i].ezr, vecs[i].eng);
      @(negedge clk);
      chk("vec done rsp_valid", bus.rsp_valid, 2'b00);
      chk("vec done busy", bus.busy, 1'b0);
    end

    // Both ports continuously valid: grants alternate 0,1,0,1
    drive(0, 16'h1357, 16'h2468, ALU_NEG1);
    drive(1, 16'hFFFF, 16'h0001, ALU_ADD);
    for (int k = 0; k < 4; k++) begin
      #1 chk("rr req_ready", bus.req_ready, oh(k % 2));
      @(negedge clk);
      chk("rr EXEC busy", bus.busy, 1'b1);
      @(negedge clk);
      if (k % 2 == 0) chk_rsp("rr p0", 0, 16'hFFFF, 1'b0, 1'b1);
      else            chk_rsp("rr p1", 1, 16'h0000, 1'b1, 1'b0);
      @(negedge clk);
    end
    bus.req_valid = '0;

    // Backpressure on port 0 while port 1 waits
    bus.rsp_ready = 2'b00;
    drive(0, 16'h0F0F, 16'h00F0, ALU_ADD);
    #1 chk("bp req_ready p0", bus.req_ready, 2'b01);
    @(posedge clk); #1;
    bus.req_valid = '0;
    drive(1, 16'h8001, 16'h5A5A, ALU_X);
    @(negedge clk);
    @(negedge clk);
    chk_rsp("bp first", 0, 16'h0FFF, 1'b0, 1'b0);
    for (int c = 0; c < 5; c++) begin
      bus.rsp_ready[1] = c[0];
      @(negedge clk);
      chk_rsp("bp hold", 0, 16'h0FFF, 1'b0, 1'b0);
      chk("bp hold busy", bus.busy, 1'b1);
    end
    bus.rsp_ready = 2'b01;
    @(negedge clk);
    chk("bp released rsp_valid", bus.rsp_valid, 2'b00);
    #1 chk("bp p1 granted", bus.req_ready, 2'b10);
    bus.rsp_ready = 2'b11;
    @(posedge clk); #1 bus.req_valid = '0;
    @(negedge clk);
    @(negedge clk);
    chk_rsp("bp p1", 1, 16'h8001, 1'b0, 1'b1);
    @(negedge clk);

    // Fairness after an idle gap: port 0 served, gap, then both valid
    drive(0, 16'h0001, 16'h0001, ALU_AND);
    #1 chk("fair p0 grant", bus.req_ready, 2'b01);
    @(posedge clk); #1 bus.req_valid = '0;
    @(negedge clk);
    @(negedge clk);
    chk_rsp("fair p0", 0, 16'h0001, 1'b0, 1'b0);
    repeat (4) begin
      @(negedge clk);
      chk("fair idle busy", bus.busy, 1'b0);
      chk("fair idle req_ready", bus.req_ready, 2'b00);
    end
    drive(0, 16'h0002, 16'h0003, ALU_ADD);
    drive(1, 16'h0004, 16'h0003, ALU_ADD);
    #1 chk("fair p1 wins", bus.req_ready, 2'b10);
    @(posedge clk); #1 bus.req_valid = '0;
    @(negedge clk);
    @(negedge clk);
    chk_rsp("fair p1", 1, 16'h0007, 1'b0, 1'b0);
    @(negedge clk);

    // Reset asserted mid-RESP
    bus.rsp_ready = 2'b00;
    drive(0, 16'h0000, 16'h0000, ALU_NEG1);
    @(posedge clk); #1 bus.req_valid = '0;
    @(negedge clk);
    @(negedge clk);
    chk_rsp("rst pre", 0, 16'hFFFF, 1'b0, 1'b1);
    #2 reset = 1'b1;
    #1;
    chk("rst rsp_valid", bus.rsp_valid, 2'b00);
    chk("rst busy", bus.busy, 1'b0);
    chk("rst rsp_out", bus.rsp_out, 16'h0000);
    chk("rst ng", bus.rsp_ng, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    drive(0, 16'h0001, 16'h0000, ALU_X);
    drive(1, 16'h0001, 16'h0000, ALU_X);
    #1 chk("rst ptr port0", bus.req_ready, 2'b01);
    bus.req_valid = '0;
    #1 chk("rst no response", bus.rsp_valid, 2'b00);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
